// File: rtl/exe_divider.sv
// -----------------------------------------------------------------------------
// exe_divider
//
// Purpose:
//   Multi-cycle 32-bit integer divider for the EXE stage (DIV / DIVU).
//   Radix-2 restoring algorithm on operand magnitudes, one quotient bit per
//   cycle, followed by a sign-fix cycle. The quotient goes to LO and the
//   remainder goes to HI. The EXE/MEM register captures them on the done cycle.
//
// Ports:
//   clk            pipeline clock
//   rst            asynchronous reset, active low
//   start_i        EXE holds a DIV/DIVU this cycle
//   signed_i       1 = DIV (signed), 0 = DIVU; sampled with start_i
//   dividend_i     rs value after bypass
//   divisor_i      rt value after bypass
//   flush_i        cancel any operation in flight (exception / MEM flush)
//   stall_o        freeze PC, IF/ID and ID/EXE while the divide is in progress
//   done_o         one-cycle pulse, results valid
//   quotient_o     quotient (to LO), registered
//   remainder_o    remainder (to HI), registered
//   div_by_zero_o  divisor was zero; valid while done_o = 1
//
// Build option:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor seen at start skips the
//                     iteration phase and completes two cycles after start.
// -----------------------------------------------------------------------------
module exe_divider #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div_by_zero_o
);

  localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;        // partial remainder (always < divisor)
  logic [31:0]   quo_q, quo_d;        // dividend shifts out, quotient shifts in
  logic [31:0]   dvs_q, dvs_d;        // divisor magnitude
  logic [31:0]   dvd_raw_q, dvd_raw_d; // raw dividend, for the divide-by-zero remainder
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic          zero_q, zero_d;
  logic [31:0]   quotient_q, quotient_d;
  logic [31:0]   remainder_q, remainder_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  // Iteration datapath: shift {rem, quo} left by one and trial-subtract.
  // The 33-bit shifted value is below 2*divisor, so bit 32 of the difference
  // is a reliable "negative" flag for a non-zero divisor.
  logic [32:0] shifted;
  logic [32:0] trial;

  // Operand magnitudes; 0x80000000 maps to itself, which is the correct
  // unsigned magnitude, so the most-negative case needs no special handling.
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    dvd_mag = (signed_i && dividend_i[31]) ? (~dividend_i + 32'd1) : dividend_i;
    dvs_mag = (signed_i && divisor_i[31])  ? (~divisor_i  + 32'd1) : divisor_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_raw_d   = dvd_raw_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    stall_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          stall_o   = 1'b1;
          rem_d     = 32'd0;
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          dvd_raw_d = dividend_i;
          q_neg_d   = signed_i & (dividend_i[31] ^ divisor_i[31]);
          r_neg_d   = signed_i & dividend_i[31];
          zero_d    = (divisor_i == 32'd0);
          cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
          state_d   = (divisor_i == 32'd0) ? S_SIGN : S_DIV;
`else
          state_d   = S_DIV;
`endif
        end
      end

      S_DIV: begin
        stall_o = 1'b1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        stall_o = 1'b1;
        if (zero_q) begin
          // Zero divisor: fixed result in both modes, remainder is the
          // dividend exactly as it was presented.
          quotient_d  = 32'hFFFF_FFFF;
          remainder_d = dvd_raw_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
          remainder_d = r_neg_q ? (~rem_q + 32'd1) : rem_q;
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush cancels everything in flight: results registers keep their
    // previous contents and no completion pulse is produced.
    if (flush_i) begin
      state_d     = S_IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      dvd_raw_q   <= 32'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_raw_q   <= dvd_raw_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_exe_divider.sv
module tb_exe_divider;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_by_zero_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  exe_divider #(.ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_i     (signed_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge; start_i is driven in that cycle
  // (cycle 0). Leaves just after the falling edge following the done cycle.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic exp_z,
                        input int exp_lat, input logic poke);
    int  lat;
    logic got_done;
    logic stall_bad;
    lat       = 0;
    got_done  = 1'b0;
    stall_bad = 1'b0;
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    #1;
    chk({tag, " stall_c0"}, {31'd0, stall_o}, 32'd1);
    for (int k = 1; k <= 60 && !got_done; k++) begin
      @(negedge clk);
      // Operands change after the start cycle; the divider must not notice.
      dividend_i = 32'hDEAD_BEEF;
      divisor_i  = 32'h0000_0003;
      signed_i   = ~sgn;
      start_i    = poke && (k == 5 || k == 20);
      #1;
      if (done_o) begin
        got_done = 1'b1;
        lat      = k;
      end else if (!stall_o) begin
        stall_bad = 1'b1;
      end
    end
    start_i = 1'b0;
    chk({tag, " done_seen"}, {31'd0, got_done}, 32'd1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " stall_busy"}, {31'd0, stall_bad}, 32'd0);
    chk({tag, " stall_done"}, {31'd0, stall_o}, 32'd0);
    chk({tag, " quotient"}, quotient_o, exp_q);
    chk({tag, " remainder"}, remainder_o, exp_r);
    chk({tag, " dbz"}, {31'd0, div_by_zero_o}, {31'd0, exp_z});
    $display("op %s: a=%h b=%h signed=%0d -> q=%h r=%h dbz=%0d latency=%0d",
             tag, a, b, sgn, quotient_o, remainder_o, div_by_zero_o, lat);
    @(negedge clk);
    #1;
    chk({tag, " done_pulse"}, {31'd0, done_o}, 32'd0);
    chk({tag, " q_hold"}, quotient_o, exp_q);
  endtask

  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    flush_i    = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst quotient", quotient_o, 32'd0);
    chk("rst remainder", remainder_o, 32'd0);
    chk("rst done", {31'd0, done_o}, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero_o}, 32'd0);
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("divu_100_7",  1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0, 34,   1'b0);
    run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34,   1'b0);
    run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,  32'd0,         1'b0, 34,   1'b0);
    run_op("div_min_m1",  1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,  32'd0,         1'b0, 34,   1'b0);
    run_op("divu_by0",    1'b0, 32'h00001234,  32'd0,          32'hFFFFFFFF,  32'h00001234,  1'b1, ZLAT, 1'b0);
    run_op("div_neg_by0", 1'b1, 32'hFFFFFFF0,  32'd0,          32'hFFFFFFFF,  32'hFFFFFFF0,  1'b1, ZLAT, 1'b0);
    run_op("div_100_m7",  1'b1, 32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,  32'd2,         1'b0, 34,   1'b0);
    run_op("divu_poke",   1'b0, 32'd1000,      32'd3,          32'd333,       32'd1,         1'b0, 34,   1'b1);

    // Flush at iteration 10 (DIV cycle 11) of DIVU 50/5
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      flush_i = (k == 11);
    end
    #1;
    chk("flush stall_during", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush stall_after", {31'd0, stall_o}, 32'd0);
    chk("flush done", {31'd0, done_o}, 32'd0);
    chk("flush q_hold", quotient_o, 32'd333);
    chk("flush r_hold", remainder_o, 32'd1);
    $display("op flush: divu 50/5 cancelled, q=%h r=%h done=%0d", quotient_o, remainder_o, done_o);
    run_op("divu_9_4",    1'b0, 32'd9,         32'd4,          32'd2,         32'd1,         1'b0, 34,   1'b0);

    // Reset at iteration 20 (DIV cycle 21) of DIVU 1000/3
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    chk("midrst quotient", quotient_o, 32'd0);
    chk("midrst remainder", remainder_o, 32'd0);
    chk("midrst done", {31'd0, done_o}, 32'd0);
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    $display("op reset: divu 1000/3 aborted, q=%h r=%h", quotient_o, remainder_o);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst done_after", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    run_op("divu_7_7",    1'b0, 32'd7,         32'd7,          32'd1,         32'd0,         1'b0, 34,   1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_divider.md
# exe_divider

Multi-cycle 32-bit integer divider in the EXE stage, serving OP_DIV and OP_DIVU. It latches operands from the ID/EXE pipeline register outputs and performs a radix-2 restoring divide. While busy it stalls the front end. It then presents quotient (for LO) and remainder (for HI), which the EXE/MEM register captures on the done cycle alongside RegsWrType.HILOWr.

## Interface
Parameters:
- ITER, 32, number of restoring iterations; equals the operand width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  EXE holds a DIV/DIVU this cycle.
- signed_i  in  1  1 = DIV, 0 = DIVU; sampled with start_i.
- dividend_i  in  32  rs value after bypass (EXE_BusA path).
- divisor_i  in  32  rt value after bypass (EXE_BusB path).
- flush_i  in  1  exception or MEM_Flush; cancels the operation.
- stall_o  out  1  freeze PC, IF/ID and ID/EXE.
- done_o  out  1  one-cycle pulse; results valid.
- quotient_o  out  32  to LO.
- remainder_o  out  32  to HI.
- div_by_zero_o  out  1  divisor was 0; valid while done_o=1.

## Operation
- States: IDLE, DIV, SIGN, DONE.
- IDLE, with start_i=1 and flush_i=0:
  - Latch |dividend| and |divisor| (magnitudes only when signed_i=1).
  - Latch sign flags: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend).
  - Latch zero flag = (divisor_i == 0).
  - Clear the iteration counter and go to DIV.
- DIV, one iteration per cycle, using a 33-bit partial remainder:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and set quo[0]=1.
  - Counter increments 0..31; after the iteration with counter=31, go to SIGN.
- SIGN:
  - Negate quo if q_neg; negate rem if r_neg.
  - Register the results into quotient_o and remainder_o; go to DONE.
- Divide by zero overrides the SIGN result: quotient_o=0xFFFFFFFF, remainder_o=dividend_i as originally latched (raw value), div_by_zero_o=1, in both modes.
- Signed 0x80000000 / 0xFFFFFFFF: quotient_o=0x80000000, remainder_o=0. This falls out of the magnitude path and needs no trap.
- DONE: done_o=1 for exactly one cycle; go to IDLE on the next edge.
- stall_o = (IDLE & start_i & ~flush_i) | DIV | SIGN. It is combinational and deasserted in DONE, so the pipeline advances with the results.
- start_i outside IDLE is ignored; operands are not re-sampled.
- flush_i=1 in any state: IDLE at the next edge, done_o not asserted, quotient_o and remainder_o hold their previous values. Flush wins over a simultaneous start_i.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - quotient_o=0, remainder_o=0, done_o=0, div_by_zero_o=0, counter=0.
  - stall_o follows its equation; it is 0 unless start_i is high.
  - Reset mid-operation aborts immediately with no done_o.
- Start accepted at edge E0:
  - DIV occupies edges E1..E32; SIGN is registered at E33.
  - done_o is high during the cycle after E33, i.e. 34 cycles after the start cycle.
  - State returns to IDLE at E34.
- A back-to-back DIV may start in the cycle after DONE.
- Outputs are registered and stable from DONE until the next completion; done_o is the only pulse.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - A zero divisor detected at E0 jumps straight to SIGN, skipping DIV.
  - done_o is high 2 cycles after the start cycle; results are the zero-divide values above.
- DIV_ZERO_FAST_EN undefined:
  - A zero divisor runs the full 34-cycle sequence.
  - Results and div_by_zero_o are identical to the defined case.

## Test plan
- DIVU 100 / 7 -> done_o exactly 34 cycles after start; quotient_o=14, remainder_o=2; stall_o high for cycles 0..33 and low on the done cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF; DIVU 0xFFFFFFFF / 1 -> quotient_o=0xFFFFFFFF, remainder_o=0.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient_o=0x80000000, remainder_o=0, div_by_zero_o=0.
- DIVU 0x1234 / 0 -> quotient_o=0xFFFFFFFF, remainder_o=0x1234, div_by_zero_o=1; done_o at cycle 34 without DIV_ZERO_FAST_EN and at cycle 2 with it.
- Start DIVU 50/5; assert flush_i at iteration 10 -> IDLE next cycle, no done_o, outputs unchanged; a new DIVU 9/4 the next cycle -> quotient_o=2, remainder_o=1.
- Drop rst at iteration 20 -> all outputs 0 immediately; raising start_i again during the busy period of a later op (not in IDLE) has no effect on its result.
